// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and helpers.
// Imported by the interface, the lane extractor and the unit top.
package lsu_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RESP      = 2'd2
   } state_t;

   localparam logic [31:0] MMIO_WORD_DEF = 32'hFFFF_FFFF;

   // Encoding 3 is reserved; it behaves as a word access.
   function automatic size_t norm_size(input logic [1:0] s);
      return (s == 2'd3) ? SIZE_WORD : size_t'(s);
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle and memory-side bus for the LSU.
// Core: req_* / resp_* valid-ready. Mem: word addresses, data, byte enables.
interface lsu_core_if #(
   parameter int AW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [AW-1:0] req_address;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_rdata;
   logic          resp_error;

   modport master (
      output req_valid, req_write, req_size,
      output req_unsigned, req_address, req_wdata,
      output resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_size,
      input  req_unsigned, req_address, req_wdata,
      input  resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

interface lsu_mem_if;
   logic [31:0] mem_read_address;
   logic [31:0] mem_read_data;
   logic [31:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_write_enable;

   modport master (
      output mem_read_address, mem_write_address,
      output mem_write_data, mem_write_enable,
      input  mem_read_data
   );

   modport slave (
      input  mem_read_address, mem_write_address,
      input  mem_write_data, mem_write_enable,
      output mem_read_data
   );
endinterface

// File: rtl/lsu_load_extract.sv
// Combinational load lane select and sign/zero extension.
// Ports: data, offset (byte addr[1:0]), size, zero_ext -> result.
module lsu_load_extract
   import lsu_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  offset,
   input  size_t       size,
   input  logic        zero_ext,
   output logic [31:0] result
);

   logic [7:0]  b;
   logic [15:0] h;
   logic        b_sign;
   logic        h_sign;

   always_comb begin
      b      = data[{offset, 3'b000} +: 8];
      // Half lane follows offset[1] only; offset[0] is ignored.
      h      = offset[1] ? data[31:16] : data[15:0];
      b_sign = ~zero_ext & b[7];
      h_sign = ~zero_ext & h[15];
      unique case (size)
         SIZE_BYTE: result = {{24{b_sign}}, b};
         SIZE_HALF: result = {{16{h_sign}}, h};
         default:   result = data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: core byte/half/word requests to word-addressed memory.
// Ports: clock, reset, core (lsu_core_if.slave), mem (lsu_mem_if.master).
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses return resp_error.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] MMIO_WORD  = MMIO_WORD_DEF
) (
   input  logic        clock,
   input  logic        reset,
   lsu_core_if.slave   core,
   lsu_mem_if.master   mem
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   size_t                 size_q;
   logic                  uns_q;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   size_t                 size_in;
   logic                  accept;
   logic                  misalign;
   logic [3:0]            lanes;
   logic [31:0]           wdata_rep;
   logic [31:0]           ext_data;
   logic [ADDR_WIDTH-1:0] rd_sel;

   // The all-ones word is remapped to the memory's LED register.
   function automatic logic [31:0] word_of(
      input logic [ADDR_WIDTH-1:0] a
   );
      logic [ADDR_WIDTH-3:0] w;
      w = a[ADDR_WIDTH-1:2];
      return (&w) ? MMIO_WORD : 32'(w);
   endfunction

   assign size_in = norm_size(core.req_size);
   assign accept  = core.req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      unique case (size_in)
         SIZE_HALF: misalign = core.req_address[0];
         SIZE_WORD: misalign = |core.req_address[1:0];
         default:   misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      unique case (size_in)
         SIZE_BYTE: begin
            lanes     = 4'b0001 << core.req_address[1:0];
            wdata_rep = {4{core.req_wdata[7:0]}};
         end
         SIZE_HALF: begin
            lanes     = core.req_address[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{core.req_wdata[15:0]}};
         end
         default: begin
            lanes     = 4'hF;
            wdata_rep = core.req_wdata;
         end
      endcase
   end

   lsu_load_extract u_extract (
      .data     (mem.mem_read_data),
      .offset   (addr_q[1:0]),
      .size     (size_q),
      .zero_ext (uns_q),
      .result   (ext_data)
   );

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               rdata_d = '0;
               err_d   = misalign;
               if (core.req_write || misalign)
                  state_d = RESP;
               else
                  state_d = LOAD_WAIT;
            end
         end
         LOAD_WAIT: begin
            rdata_d = ext_data;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            if (core.resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         size_q  <= SIZE_WORD;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            addr_q <= core.req_address;
            size_q <= size_in;
            uns_q  <= core.req_unsigned;
         end
      end
   end

   assign core.req_ready  = (state_q == IDLE);
   assign core.resp_valid = (state_q == RESP);
   assign core.resp_rdata = rdata_q;
   assign core.resp_error = err_q;

   // Address goes out with the request so read data lands at T+1.
   assign rd_sel = (state_q == IDLE) ? core.req_address : addr_q;
   assign mem.mem_read_address  = word_of(rd_sel);
   assign mem.mem_write_address = word_of(core.req_address);
   assign mem.mem_write_data    = wdata_rep;
   assign mem.mem_write_enable  =
      (accept && core.req_write && !misalign && !reset) ? lanes : 4'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 16-word memory model.
// Scoreboard queue holds expected responses; tasks check inline.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   lsu_core_if #(.AW(32)) core ();
   lsu_mem_if mem ();

   load_store_unit #(
      .ADDR_WIDTH (32),
      .MMIO_WORD  (32'hFFFF_FFFF)
   ) dut (
      .clock (clock),
      .reset (reset),
      .core  (core),
      .mem   (mem)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic [31:0] ram    [0:15];
   logic [31:0] shadow [0:15];
   logic [31:0] mmio_q;
   resp_t       sb [$];
   int          vectors = 0;
   int          errors  = 0;

   always @(posedge clock) begin
      mem.mem_read_data <= ram[mem.mem_read_address[3:0]];
      if (mem.mem_write_address == 32'hFFFF_FFFF) begin
         if (|mem.mem_write_enable) mmio_q <= mem.mem_write_data;
      end else begin
         for (int i = 0; i < 4; i++)
            if (mem.mem_write_enable[i])
               ram[mem.mem_write_address[3:0]][8*i +: 8]
                  <= mem.mem_write_data[8*i +: 8];
      end
   end

   function automatic logic f_mis(input logic [1:0] sz,
                                  input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
      return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] f_we(input logic [1:0] sz,
                                       input logic [31:0] a);
      case (sz)
         2'd0:    return 4'b0001 << a[1:0];
         2'd1:    return a[1] ? 4'hC : 4'h3;
         default: return 4'hF;
      endcase
   endfunction

   function automatic logic [31:0] f_wd(input logic [1:0] sz,
                                        input logic [31:0] d);
      case (sz)
         2'd0:    return {4{d[7:0]}};
         2'd1:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] f_wa(input logic [31:0] a);
      return (&a[31:2]) ? 32'hFFFF_FFFF : {2'b00, a[31:2]};
   endfunction

   function automatic logic [31:0] f_ld(input logic [31:0] w,
                                        input logic [31:0] a,
                                        input logic [1:0]  sz,
                                        input logic        u);
      logic [31:0] v;
      int sh;
      sh = (sz == 2'd0) ? 8 * int'(a[1:0]) :
           (sz == 2'd1) ? 16 * int'(a[1]) : 0;
      v = w >> sh;
      if (sz == 2'd0)
         v = u ? (v & 32'hFF) : 32'($signed(v[7:0]));
      else if (sz == 2'd1)
         v = u ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
      return v;
   endfunction

   task automatic do_req(input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] wd,
                         input logic [31:0] e_rd);
      logic       mis;
      logic [3:0] e_we;
      int         lat;
      int         cyc;
      resp_t      exp_r;
      resp_t      got;
      mis  = f_mis(sz, a);
      e_we = (w && !mis) ? f_we(sz, a) : 4'h0;
      lat  = (w || mis) ? 1 : 2;
      @(negedge clock);
      core.req_valid    = 1'b1;
      core.req_write    = w;
      core.req_size     = sz;
      core.req_unsigned = u;
      core.req_address  = a;
      core.req_wdata    = wd;
      #1;
      vectors++;
      if (core.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready a=%h: got %b want 1", a, core.req_ready);
      end
      vectors++;
      if (mem.mem_write_enable !== e_we) begin
         errors++;
         $display("FAIL write_enable a=%h: got %h want %h",
                  a, mem.mem_write_enable, e_we);
      end
      if (e_we != 4'h0) begin
         vectors++;
         if (mem.mem_write_address !== f_wa(a) ||
             mem.mem_write_data !== f_wd(sz, wd)) begin
            errors++;
            $display("FAIL write_bus a=%h: got %h/%h want %h/%h",
                     a, mem.mem_write_address, mem.mem_write_data,
                     f_wa(a), f_wd(sz, wd));
         end
         if (f_wa(a) != 32'hFFFF_FFFF)
            for (int i = 0; i < 4; i++)
               if (e_we[i])
                  shadow[a[5:2]][8*i +: 8] = f_wd(sz, wd) >> (8 * i);
      end
      sb.push_back('{rdata: (w || mis) ? 32'h0 : e_rd, err: mis});
      @(posedge clock);
      @(negedge clock);
      core.req_valid = 1'b0;
      cyc = 1;
      while (core.resp_valid !== 1'b1 && cyc < 8) begin
         @(negedge clock);
         cyc++;
      end
      vectors++;
      if (core.resp_valid !== 1'b1 || cyc != lat) begin
         errors++;
         $display("FAIL latency a=%h: got %0d want %0d", a, cyc, lat);
      end
      exp_r = sb.pop_front();
      if (core.resp_valid === 1'b1) begin
         got = '{rdata: core.resp_rdata, err: core.resp_error};
         vectors++;
         if (got !== exp_r) begin
            errors++;
            $display("FAIL resp a=%h: got %h/%b want %h/%b",
                     a, got.rdata, got.err, exp_r.rdata, exp_r.err);
         end
         core.resp_ready = 1'b1;
         @(posedge clock);
         @(negedge clock);
         core.resp_ready = 1'b0;
         vectors++;
         if (core.req_ready !== 1'b1 || core.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: got %b/%b want 1/0",
                     core.req_ready, core.resp_valid);
         end
      end
   endtask

   task automatic test_reset();
      reset             = 1'b1;
      core.req_valid    = 1'b1;
      core.req_write    = 1'b1;
      core.req_size     = 2'd2;
      core.req_unsigned = 1'b0;
      core.req_address  = 32'h0;
      core.req_wdata    = 32'hDEAD_BEEF;
      core.resp_ready   = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      vectors++;
      if (mem.mem_write_enable !== 4'h0) begin
         errors++;
         $display("FAIL reset_we: got %h want 0", mem.mem_write_enable);
      end
      vectors++;
      if (core.resp_valid !== 1'b0 || core.req_ready !== 1'b1 ||
          core.resp_rdata !== 32'h0 || core.resp_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got v%b r%b %h e%b want v0 r1 0 e0",
                  core.resp_valid, core.req_ready,
                  core.resp_rdata, core.resp_error);
      end
      core.req_valid = 1'b0;
      reset          = 1'b0;
   endtask

   task automatic test_store_load();
      do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h8000_F0FF, 32'h0);
      do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 32'hFFFF_8000);
      do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, 32'h0000_8000);
      do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_00AB, 32'h0);
      do_req(1'b0, 2'd0, 1'b0, 32'h6, 32'h0, 32'hFFFF_FFAB);
      do_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 32'h0000_0080);
      do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h80AB_F0FF);
      do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 32'hFFFF_F0FF);
   endtask

   task automatic test_mmio();
      do_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h5A, 32'h0);
      vectors++;
      if (mmio_q !== 32'h0000_005A) begin
         errors++;
         $display("FAIL mmio: got %h want 0000005a", mmio_q);
      end
   endtask

   task automatic test_reserved_size();
      do_req(1'b0, 2'd3, 1'b0, 32'h4, 32'h0, 32'h80AB_F0FF);
   endtask

   task automatic test_misalign();
      do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'h1234_5678, 32'h0);
      do_req(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, 32'hFFFF_F0FF);
   endtask

   task automatic test_backpressure();
      resp_t exp_r;
      logic  ok;
      @(negedge clock);
      core.req_valid    = 1'b1;
      core.req_write    = 1'b0;
      core.req_size     = 2'd0;
      core.req_unsigned = 1'b1;
      core.req_address  = 32'h5;
      sb.push_back('{rdata: 32'h0000_00F0, err: 1'b0});
      @(posedge clock);
      @(negedge clock);
      core.req_write   = 1'b1;
      core.req_size    = 2'd2;
      core.req_address = 32'h0;
      core.req_wdata   = 32'hFFFF_FFFF;
      @(negedge clock);
      exp_r = sb.pop_front();
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (core.resp_valid !== 1'b1 || core.req_ready !== 1'b0 ||
             core.resp_rdata !== exp_r.rdata ||
             core.resp_error !== exp_r.err ||
             mem.mem_write_enable !== 4'h0)
            ok = 1'b0;
         @(negedge clock);
      end
      vectors++;
      if (!ok) begin
         errors++;
         $display("FAIL backpressure: got %h want %h held",
                  core.resp_rdata, exp_r.rdata);
      end
      core.req_valid  = 1'b0;
      core.resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      core.resp_ready = 1'b0;
      vectors++;
      if (core.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: got %b want 1", core.req_ready);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clock);
      core.req_valid    = 1'b1;
      core.req_write    = 1'b0;
      core.req_size     = 2'd2;
      core.req_address  = 32'h4;
      @(posedge clock);
      @(negedge clock);
      core.req_valid = 1'b0;
      reset          = 1'b1;
      core.resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      vectors++;
      if (core.resp_valid !== 1'b0 || core.resp_rdata !== 32'h0 ||
          core.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got v%b %h r%b want v0 0 r1",
                  core.resp_valid, core.resp_rdata, core.req_ready);
      end
      seen = 0;
      repeat (4) begin
         @(negedge clock);
         if (core.resp_valid === 1'b1) seen++;
      end
      core.resp_ready = 1'b0;
      vectors++;
      if (seen != 0) begin
         errors++;
         $display("FAIL dropped_resp: got %0d responses want 0", seen);
      end
   endtask

   task automatic test_random_seq();
      logic [31:0] a;
      logic [1:0]  sz;
      logic        w;
      logic        u;
      logic [31:0] d;
      do_req(1'b1, 2'd2, 1'b0, 32'h0, $urandom, 32'h0);
      do_req(1'b1, 2'd2, 1'b0, 32'h4, $urandom, 32'h0);
      for (int n = 0; n < 12; n++) begin
         sz = 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, 7));
         if (sz == 2'd1) a[0] = 1'b0;
         if (sz == 2'd2) a[1:0] = 2'b00;
         w = 1'($urandom_range(0, 1));
         u = 1'($urandom_range(0, 1));
         d = $urandom;
         do_req(w, sz, u, a, d,
                w ? 32'h0 : f_ld(shadow[a[5:2]], a, sz, u));
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_mmio();
      test_reserved_size();
      test_misalign();
      test_backpressure();
      test_reset_mid();
      test_random_seq();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
